seq_detect_mealy: RTL and testbench
===================================

SEQ_DETECT_MEALY -- requirements
Module: seq_detect_mealy

Interface
REQ-001 Parameter PAT_W, default 5, pattern length in bits (legal 2..16).
REQ-002 Parameter CNT_W, default 8, width of match counter.
REQ-003 Parameter PAT_RST, default 5'b10111 (PAT_W bits), pattern value after reset.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 inp  in  1  serial data bit.
REQ-007 in_valid  in  1  inp qualifier; bit consumed only when high.
REQ-008 overlap  in  1  mode: 1 = overlapping matches, 0 = non-overlapping.
REQ-009 pat_load  in  1  single-cycle strobe; load pat_in into pattern register.
REQ-010 pat_in  in  PAT_W  new pattern, MSB is first bit received.
REQ-011 outp  out  1  Mealy match output, combinational from state and current inp.
REQ-012 hist  out  PAT_W  registered shift history of accepted bits, newest in LSB.
REQ-013 match_cnt  out  CNT_W  registered count of matches.
REQ-014 cnt_sat  out  1  high when match_cnt equals all-ones.

Function
REQ-015 State: pattern register, hist shift register, fill counter (0..PAT_W-1, saturating), match counter.
REQ-016 Accepted bit (in_valid=1, pat_load=0): hist <= {hist[PAT_W-2:0], inp} on the next edge.
REQ-017 Fill counter increments per accepted bit, saturates at PAT_W-1.
REQ-018 outp = in_valid & ~pat_load & (fill == PAT_W-1) & ({hist[PAT_W-2:0], inp} == pattern), same cycle, zero latency.
REQ-019 outp is 0 whenever in_valid=0, pat_load=1, or reset asserted.
REQ-020 On a match with overlap=1: fill stays PAT_W-1; the next bit may complete another match.
REQ-021 On a match with overlap=0: fill <= 0 and hist <= 0 on that edge; next match needs PAT_W fresh bits.
REQ-022 overlap is sampled each cycle; a mode change affects only the current and subsequent matches.
REQ-023 match_cnt increments by 1 on each edge where outp=1; holds at all-ones (no wrap).
REQ-024 pat_load=1: pattern <= pat_in, hist <= 0, fill <= 0, match_cnt unchanged; any simultaneous inp is discarded.
REQ-025 in_valid=0 and pat_load=0: all state holds.
REQ-026 Pattern of all zeros or all ones is legal; detection follows REQ-018 unchanged.

Reset
REQ-027 rst low asynchronously forces hist=0, fill=0, match_cnt=0, pattern=PAT_RST; outp=0, cnt_sat=0.
REQ-028 Reset mid-sequence discards partial progress; first match after release needs PAT_W accepted bits.
REQ-029 Reset release is synchronous to clk; first accepted bit is the first rising edge with rst high and in_valid high.

Structure
REQ-030 Shared package seq_detect_pkg holds default PAT_W, CNT_W, PAT_RST and the fill-counter width function (clog2 of PAT_W).
REQ-031 One sub-module, sat_counter (parametrised CNT_W, increment enable, saturate flag), implements match_cnt/cnt_sat.
REQ-032 Single always block per register group; no latches; outp is the only combinational output.

Verification
REQ-033 Defaults, reset, stream 1,0,1,1,1 valid each cycle -> outp=1 only in 5th cycle, match_cnt=1 after.
REQ-034 Load 3'b101 (PAT_W=3), overlap=1, stream 1,0,1,0,1 -> outp high cycles 3 and 5, match_cnt=2.
REQ-035 Same as REQ-034 with overlap=0 -> outp high cycle 3 only, match_cnt=1, hist=3'b001 at end.
REQ-036 Stream 1,0,1,1 then rst low mid-cycle then 1 -> no match; outp=0, hist=0 immediately on rst.
REQ-037 CNT_W=2, pattern 2'b11, overlap=1, five 1s -> match_cnt 0,0,1,2,3,3; cnt_sat high from 3rd match.
REQ-038 pat_load with in_valid=1 during final bit of pattern -> outp=0, inp ignored, hist=0, new pattern active next cycle.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared defaults, step encoding and width helper for seq_detect_mealy
//
// Purpose : defaults for the serial pattern detector, the per-cycle step
//           classification used by the top, and the fill-counter width helper.
// Contents: PAT_W_DEF, CNT_W_DEF, PAT_RST_DEF, step_e, fill_w().
package seq_detect_pkg;

    localparam int         PAT_W_DEF   = 5;
    localparam int         CNT_W_DEF   = 8;
    localparam logic [4:0] PAT_RST_DEF = 5'b10111;

    // What the history/fill registers do on the coming edge.
    typedef enum logic [1:0] {
        STEP_HOLD  = 2'd0,  // no accepted bit, no load
        STEP_SHIFT = 2'd1,  // accepted bit, keep progress
        STEP_CLEAR = 2'd2,  // accepted bit completed a non-overlapping match
        STEP_LOAD  = 2'd3   // new pattern, progress discarded
    } step_e;

    // Fill counts 0..pat_w-1, so clog2(pat_w) bits suffice; never below one bit.
    function automatic int fill_w(input int pat_w);
        return (pat_w < 2) ? 1 : $clog2(pat_w);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with registered all-ones flag
//
// Purpose : counts enable pulses and sticks at all-ones instead of wrapping.
// Ports   : clk   - clock, rising edge
//           rst   - asynchronous active-low reset
//           en    - increment request for this edge
//           count - current count (CNT_W bits)
//           sat   - high exactly when count is all-ones
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] count_inc;

    assign count_inc = count + CNT_W'(1);

    // sat is registered alongside count so it tracks count without a
    // combinational reduction on the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (en && !sat) begin
            count <= count_inc;
            sat   <= &count_inc;
        end
    end

endmodule

// File: rtl/seq_detect_mealy.sv
// rtl/seq_detect_mealy.sv - Mealy serial pattern detector with loadable pattern and match counter
//
// Purpose : watches a qualified serial bit stream for a PAT_W-bit pattern
//           (MSB received first), flagging a match in the same cycle as the
//           completing bit. Supports overlapping and non-overlapping modes.
// Ports   : clk       - clock, rising edge
//           rst       - asynchronous active-low reset
//           inp       - serial data bit
//           in_valid  - inp is consumed only when high
//           overlap   - 1: matches may overlap, 0: restart after each match
//           pat_load  - strobe: take pat_in as the new pattern, drop progress
//           pat_in    - new pattern value
//           outp      - combinational match flag for the current bit
//           hist      - accepted-bit history, newest bit in LSB
//           match_cnt - saturating match count
//           cnt_sat   - match_cnt is all-ones
module seq_detect_mealy
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_RST_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             outp,
    output logic [PAT_W-1:0] hist,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int               FILL_W   = fill_w(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pattern_q;
    logic [PAT_W-1:0]  hist_q;
    logic [FILL_W-1:0] fill_q;
    logic [PAT_W-1:0]  next_hist;
    logic              accept;
    logic              full;
    logic              match_hit;
    step_e             step;

    // A load takes priority over data: the bit presented alongside it is dropped.
    assign accept    = in_valid & ~pat_load;
    assign next_hist = {hist_q[PAT_W-2:0], inp};
    // full means PAT_W-1 bits are already held, so this bit can complete a match.
    assign full      = (fill_q == FILL_MAX);
    assign match_hit = accept & full & (next_hist == pattern_q);

    // Gating with rst keeps outp low for the whole reset window, independent
    // of how the cleared registers happen to compare.
    assign outp = rst & match_hit;
    assign hist = hist_q;

    always_comb begin
        step = STEP_HOLD;
        if (pat_load) begin
            step = STEP_LOAD;
        end else if (in_valid) begin
            if (match_hit && !overlap) begin
                step = STEP_CLEAR;
            end else begin
                step = STEP_SHIFT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern_q <= PAT_RST;
        end else if (step == STEP_LOAD) begin
            pattern_q <= pat_in;
        end
    end

    // In overlap mode fill stays pinned at FILL_MAX after a match, so the
    // very next bit is judged against the shifted history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            case (step)
                STEP_LOAD, STEP_CLEAR: begin
                    hist_q <= '0;
                    fill_q <= '0;
                end
                STEP_SHIFT: begin
                    hist_q <= next_hist;
                    if (!full) begin
                        fill_q <= fill_q + FILL_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (outp),
        .count (match_cnt),
        .sat   (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detect_mealy.sv
// tb/tb_seq_detect_mealy.sv - self-checking bench for seq_detect_mealy
module tb_seq_detect_mealy;

    logic       clk = 1'b0;
    logic       rst;
    logic       inp;
    logic       in_valid;
    logic       overlap;
    logic       pat_load;
    logic [4:0] pat_in5;
    logic [2:0] pat_in3;
    logic [1:0] pat_in2;

    logic       outp5, outp3, outp2;
    logic [4:0] hist5;
    logic [2:0] hist3;
    logic [1:0] hist2;
    logic [7:0] cnt5, cnt3;
    logic [1:0] cnt2;
    logic       sat5, sat3, sat2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_detect_mealy u_d5 (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in5), .outp(outp5), .hist(hist5),
        .match_cnt(cnt5), .cnt_sat(sat5)
    );

    seq_detect_mealy #(.PAT_W(3), .CNT_W(8), .PAT_RST(3'b101)) u_d3 (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in3), .outp(outp3), .hist(hist3),
        .match_cnt(cnt3), .cnt_sat(sat3)
    );

    seq_detect_mealy #(.PAT_W(2), .CNT_W(2), .PAT_RST(2'b11)) u_d2 (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in2), .outp(outp2), .hist(hist2),
        .match_cnt(cnt2), .cnt_sat(sat2)
    );

    // Reference model: per instance, the last accepted bits as a number, how
    // many bits were accepted since the last clear, and the match count.
    int m_w[3]      = '{5, 3, 2};
    int m_cw[3]     = '{8, 8, 2};
    int m_rstpat[3] = '{23, 5, 3};
    int m_pat[3];
    int m_recent[3];
    int m_seen[3];
    int m_cnt[3];
    bit o_cap[3];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int dut_out(input int k);
        case (k)
            0:       return int'(outp5);
            1:       return int'(outp3);
            default: return int'(outp2);
        endcase
    endfunction

    function automatic int dut_hist(input int k);
        case (k)
            0:       return int'(hist5);
            1:       return int'(hist3);
            default: return int'(hist2);
        endcase
    endfunction

    function automatic int dut_cnt(input int k);
        case (k)
            0:       return int'(cnt5);
            1:       return int'(cnt3);
            default: return int'(cnt2);
        endcase
    endfunction

    function automatic int dut_sat(input int k);
        case (k)
            0:       return int'(sat5);
            1:       return int'(sat3);
            default: return int'(sat2);
        endcase
    endfunction

    function automatic int pin(input int k);
        case (k)
            0:       return int'(pat_in5);
            1:       return int'(pat_in3);
            default: return int'(pat_in2);
        endcase
    endfunction

    function automatic int m_shifted(input int k);
        return (m_recent[k] * 2 + int'(inp)) % (1 << m_w[k]);
    endfunction

    function automatic int m_out(input int k);
        if (!rst || !in_valid || pat_load) return 0;
        return ((m_seen[k] + 1 >= m_w[k]) && (m_shifted(k) == m_pat[k])) ? 1 : 0;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) begin
            m_pat[k] = m_rstpat[k];
            m_recent[k] = 0;
            m_seen[k] = 0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic m_clock();
        for (int k = 0; k < 3; k++) begin
            int hit;
            hit = m_out(k);
            if (pat_load) begin
                m_pat[k] = pin(k);
                m_recent[k] = 0;
                m_seen[k] = 0;
            end else if (in_valid) begin
                if (hit != 0 && m_cnt[k] < (1 << m_cw[k]) - 1) m_cnt[k]++;
                if (hit != 0 && !overlap) begin
                    m_recent[k] = 0;
                    m_seen[k] = 0;
                end else begin
                    m_recent[k] = m_shifted(k);
                    m_seen[k]++;
                end
            end
        end
    endtask

    task automatic check_regs();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("hist[%0d]", k), dut_hist(k), m_recent[k]);
            check($sformatf("match_cnt[%0d]", k), dut_cnt(k), m_cnt[k]);
            check($sformatf("cnt_sat[%0d]", k), dut_sat(k),
                  (m_cnt[k] == (1 << m_cw[k]) - 1) ? 1 : 0);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic cyc(input bit i, input bit v, input bit ov, input bit ld,
                       input int p5, input int p3, input int p2);
        rst = 1'b1;
        inp = i;
        in_valid = v;
        overlap = ov;
        pat_load = ld;
        pat_in5 = p5[4:0];
        pat_in3 = p3[2:0];
        pat_in2 = p2[1:0];
        #1;
        for (int k = 0; k < 3; k++) begin
            o_cap[k] = (dut_out(k) != 0);
            check($sformatf("outp[%0d]", k), dut_out(k), m_out(k));
        end
        @(posedge clk);
        m_clock();
        @(negedge clk);
        check_regs();
    endtask

    // Called at a falling edge; returns at the next falling edge with rst high.
    task automatic do_reset();
        in_valid = 1'b0;
        pat_load = 1'b0;
        rst = 1'b0;
        m_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_outp[%0d]", k), dut_out(k), 0);
        end
        check_regs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        bit i;
        bit v;
        bit ov;
        bit exp_out;
        int exp_hist;
        int exp_cnt;
    } vec_t;

    vec_t tbl[11];
    int   exp_c2[5];
    int   exp_s2[5];
    int   exp_o3a[5];
    int   exp_o3b[5];

    initial begin
        tbl[0]  = '{1, 1, 1, 0,  1, 0};
        tbl[1]  = '{0, 1, 1, 0,  2, 0};
        tbl[2]  = '{1, 1, 1, 0,  5, 0};
        tbl[3]  = '{1, 1, 1, 0, 11, 0};
        tbl[4]  = '{1, 1, 1, 1, 23, 1};
        tbl[5]  = '{1, 0, 1, 0, 23, 1};
        tbl[6]  = '{0, 1, 1, 0, 14, 1};
        tbl[7]  = '{1, 1, 1, 0, 29, 1};
        tbl[8]  = '{1, 1, 1, 0, 27, 1};
        tbl[9]  = '{1, 1, 0, 1,  0, 2};
        tbl[10] = '{1, 1, 0, 0,  1, 2};
        exp_c2  = '{0, 1, 2, 3, 3};
        exp_s2  = '{0, 0, 0, 1, 1};
        exp_o3a = '{0, 0, 1, 0, 1};
        exp_o3b = '{0, 0, 1, 0, 0};

        rst = 1'b0;
        inp = 1'b0;
        in_valid = 1'b0;
        overlap = 1'b1;
        pat_load = 1'b0;
        pat_in5 = '0;
        pat_in3 = '0;
        pat_in2 = '0;
        m_reset();
        #1;
        check("reset_outp5", int'(outp5), 0);
        check("reset_hist5", int'(hist5), 0);
        check("reset_cnt5", int'(cnt5), 0);
        check("reset_sat5", int'(sat5), 0);
        @(negedge clk);
        rst = 1'b1;

        // Default pattern 10111: first match on the fifth bit, then overlap
        // and non-overlap continuation.
        for (int n = 0; n < 11; n++) begin
            cyc(tbl[n].i, tbl[n].v, tbl[n].ov, 1'b0, 0, 0, 0);
            check($sformatf("tbl%0d_outp", n), int'(o_cap[0]), int'(tbl[n].exp_out));
            check($sformatf("tbl%0d_hist", n), int'(hist5), tbl[n].exp_hist);
            check($sformatf("tbl%0d_cnt", n), int'(cnt5), tbl[n].exp_cnt);
        end

        // PAT_W=3 pattern 101, stream 10101, overlap then non-overlap.
        for (int ov = 1; ov >= 0; ov--) begin
            do_reset();
            cyc(1'b0, 1'b0, 1'(ov), 1'b1, 23, 5, 3);
            for (int n = 0; n < 5; n++) begin
                cyc(1'((n + 1) % 2), 1'b1, 1'(ov), 1'b0, 0, 0, 0);
                check($sformatf("p3_ov%0d_outp%0d", ov, n), int'(o_cap[1]),
                      (ov != 0) ? exp_o3a[n] : exp_o3b[n]);
            end
            check($sformatf("p3_ov%0d_cnt", ov), int'(cnt3), (ov != 0) ? 2 : 1);
            check($sformatf("p3_ov%0d_hist", ov), int'(hist3), (ov != 0) ? 5 : 1);
        end

        // Asynchronous reset while the completing bit is presented.
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        inp = 1'b1;
        in_valid = 1'b1;
        #1;
        check("arst_pre_outp", int'(outp5), 1);
        #2;
        rst = 1'b0;
        m_reset();
        #1;
        check("arst_outp", int'(outp5), 0);
        check("arst_hist", int'(hist5), 0);
        check("arst_cnt", int'(cnt5), 0);
        @(posedge clk);
        @(negedge clk);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        check("arst_after_outp", int'(o_cap[0]), 0);
        check("arst_after_hist", int'(hist5), 1);
        check("arst_after_cnt", int'(cnt5), 0);

        // PAT_W=2, CNT_W=2, pattern 11: count saturates at 3.
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 23, 5, 3);
        check("sat_cnt_init", int'(cnt2), 0);
        for (int n = 0; n < 5; n++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0);
            check($sformatf("sat_cnt%0d", n), int'(cnt2), exp_c2[n]);
            check($sformatf("sat_flag%0d", n), int'(sat2), exp_s2[n]);
        end

        // Load during the completing bit, then all-ones and all-zeros patterns.
        do_reset();
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 31, 5, 3);
        check("load_outp", int'(o_cap[0]), 0);
        check("load_hist", int'(hist5), 0);
        check("load_cnt", int'(cnt5), 0);
        for (int n = 0; n < 5; n++) begin
            cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0);
            check($sformatf("ones_outp%0d", n), int'(o_cap[0]), (n == 4) ? 1 : 0);
        end
        check("ones_cnt", int'(cnt5), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 5, 3);
        for (int n = 0; n < 6; n++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
            check($sformatf("zeros_outp%0d", n), int'(o_cap[0]), (n == 4) ? 1 : 0);
        end
        check("zeros_cnt", int'(cnt5), 2);

        // Random traffic against the model.
        begin
            bit ov_r;
            ov_r = 1'b1;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 299) == 0) begin
                    do_reset();
                end
                if ($urandom_range(0, 19) == 0) ov_r = ~ov_r;
                cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ov_r,
                    ($urandom_range(0, 39) == 0), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
